// File: rtl/lzd_norm.sv
// lzd_norm: three-stage normalizer that left-shifts a mantissa to set its MSB,
// lowering the exponent and clamping at zero to yield denormals.
module lzd #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]         data,
  output logic [$clog2(WIDTH)-1:0] zp,
  output logic                     valid
);
  localparam int LW = $clog2(WIDTH);
  always_comb begin
    zp = '0;
    for (int i = 0; i < WIDTH; i++) if (data[i]) zp = LW'(WIDTH - 1 - i);
  end
  assign valid = |data;
endmodule

module lzd_norm #(
  parameter int WIDTH = 64,
  parameter int EW    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [EW-1:0]    in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [EW-1:0]    out_exp,
  output logic             out_zero,
  output logic             out_denorm
);
  localparam int LW = $clog2(WIDTH);
  logic             stall, v1, v2, z1, dn1, z2, dn2, lzd_valid_unused;
  logic [WIDTH-1:0] d1, d2;
  logic [EW-1:0]    e1, e2, zpe;
  logic [LW-1:0]    zp, sh, sh2;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  lzd #(.WIDTH(WIDTH)) u_lzd (.data(d1), .zp(zp), .valid(lzd_valid_unused));
  assign zpe = EW'(zp);
  assign z1  = ~|d1;
  assign sh  = (zpe > e1) ? e1[LW-1:0] : zp;
  assign dn1 = (zpe > e1) && !z1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      d1         <= '0;
      e1         <= '0;
      d2         <= '0;
      e2         <= '0;
      sh2        <= '0;
      z2         <= 1'b0;
      dn2        <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_exp    <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
    end else if (!stall) begin
      v1         <= in_valid && in_ready;
      d1         <= in_data;
      e1         <= in_exp;
      v2         <= v1;
      d2         <= d1 << {sh[LW-1:3], 3'b000};
      sh2        <= sh;
      e2         <= e1;
      z2         <= z1;
      dn2        <= dn1;
      out_valid  <= v2;
      out_data   <= d2 << sh2[2:0];
      out_exp    <= z2 ? '0 : e2 - EW'(sh2);
      out_zero   <= z2;
      out_denorm <= dn2;
    end
  end
endmodule

// File: tb/tb_lzd_norm.sv
// tb_lzd_norm: randomized scoreboard bench for lzd_norm against a count-leading-zeros model.
module tb_lzd_norm;
  typedef struct packed {
    logic [63:0] d;
    logic [10:0] e;
    logic        z;
    logic        dn;
  } item_t;

  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, done = 0;
  logic [63:0] in_data = 0;
  logic [10:0] in_exp = 0;
  logic        in_ready, out_valid, out_zero, out_denorm;
  logic [63:0] out_data;
  logic [10:0] out_exp;

  lzd_norm #(.WIDTH(64), .EW(11)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_exp(out_exp), .out_zero(out_zero), .out_denorm(out_denorm)
  );

  always #5 clk = ~clk;

  int    total = 0, bad = 0, cyc = 0;
  item_t q[$];
  int    pops[$];
  logic        prev_stall = 0;
  logic [63:0] pd = 0;
  logic [10:0] pe = 0;

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic item_t model(input logic [63:0] d, input logic [10:0] e);
    item_t r;
    int    lz, s;
    lz = 0;
    while (lz < 64 && !d[63-lz]) lz++;
    if (d == 0) r = item_t'{64'd0, 11'd0, 1'b1, 1'b0};
    else begin
      s    = (lz < int'(e)) ? lz : int'(e);
      r.d  = d << s;
      r.e  = e - 11'(s);
      r.z  = 1'b0;
      r.dn = lz > int'(e);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    item_t x;
    cyc <= cyc + 1;
    if (!rst_n) begin
      q.delete();
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", out_data, pd);
        check("stall_exp", 64'(out_exp), 64'(pe));
      end
      if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got data %h exp %0d with no item pending", out_data, out_exp);
        end else begin
          x = q.pop_front();
          pops.push_back(cyc);
          check("data", out_data, x.d);
          check("exp", 64'(out_exp), 64'(x.e));
          check("zero", 64'(out_zero), 64'(x.z));
          check("denorm", 64'(out_denorm), 64'(x.dn));
        end
      end
      prev_stall <= out_valid && !out_ready;
      pd         <= out_data;
      pe         <= out_exp;
    end
  end

  task automatic send(input logic [63:0] d, input logic [10:0] e, input item_t x);
    int k = 0;
    in_valid = 1;
    in_data  = d;
    in_exp   = e;
    @(negedge clk);
    while (!in_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end else q.push_back(x);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d items pending want 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int          n;
    logic [63:0] d;
    logic [10:0] e;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_exp", 64'(out_exp), 64'd0);
    check("rst_zero", 64'(out_zero), 64'd0);
    check("rst_denorm", 64'(out_denorm), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(64'h0000_0000_0000_0001, 11'd1000, item_t'{64'h8000_0000_0000_0000, 11'd937, 1'b0, 1'b0});
    send(64'h0000_0001_0000_0000, 11'd10, item_t'{64'h0000_0400_0000_0000, 11'd0, 1'b0, 1'b1});
    drain();
    n = pops.size();
    @(posedge clk);
    #1;
    send(64'd0, 11'd77, item_t'{64'd0, 11'd0, 1'b1, 1'b0});
    send(64'h8000_0000_0000_0000, 11'd5, item_t'{64'h8000_0000_0000_0000, 11'd5, 1'b0, 1'b0});
    drain();
    check("b2b_count", 64'(pops.size() - n), 64'd2);
    if (pops.size() >= n + 2) check("b2b_consecutive", 64'(pops[n+1] - pops[n]), 64'd1);
    @(posedge clk);
    #1;
    send(64'h0000_0000_0010_0000, 11'd43, item_t'{64'h8000_0000_0000_0000, 11'd0, 1'b0, 1'b0});
    send(64'h0000_0000_0000_000F, 11'd0, item_t'{64'h0000_0000_0000_000F, 11'd0, 1'b0, 1'b1});
    drain();
    n = pops.size();
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          d = 64'h0000_1000_0000_0000 >> (i * 7);
          e = 11'(100 + i);
          send(d, e, model(d, e));
        end
      end
      begin
        int k = 0;
        while (!out_valid && k < 100) begin
          @(negedge clk);
          k++;
        end
        if (!out_valid) begin
          total++;
          bad++;
          $display("FAIL bp_first_out: out_valid got 0 want 1");
        end
        @(posedge clk);
        #1 out_ready = 0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    check("bp_count", 64'(pops.size() - n), 64'd5);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      d = 64'h0000_0000_00FF_0000 << i;
      e = 11'(300 + i);
      send(d, e, model(d, e));
    end
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_data", out_data, 64'd0);
    check("midrst_exp", 64'(out_exp), 64'd0);
    check("midrst_flags", {62'd0, out_zero, out_denorm}, 64'd0);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          d = {$urandom, $urandom} >> $urandom_range(0, 63);
          if ($urandom_range(0, 15) == 0) d = 64'd0;
          e = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 70)) : 11'($urandom);
          send(d, e, model(d, e));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
